// File: rtl/uart_tx_packet_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_packet_sender: feeds a NUM_BYTES packet to Uart8, MSB byte first,  |
// | with a txDone timeout. Define TX_CHECKSUM_EN to append an XOR byte.  r1.0  |
// +----------------------------------------------------------------------------+
module uart_tx_packet_sender #(
  parameter int NUM_BYTES      = 2,
  parameter int TXDONE_TIMEOUT = 100000
) (
  input  logic                   i_Clock,
  input  logic                   rst_n,
  input  logic                   i_Send,
  input  logic [8*NUM_BYTES-1:0] i_Packet,
  output logic                   o_Ready,
  output logic                   o_Busy,
  output logic [7:0]             o_Tx_Data,
  output logic                   o_Tx_Start,
  input  logic                   i_Tx_Done,
  output logic                   o_Done,
  output logic                   o_Timeout
);

`ifdef TX_CHECKSUM_EN
  localparam int TOTAL = NUM_BYTES + 1;
`else
  localparam int TOTAL = NUM_BYTES;
`endif
  localparam int SR_W  = 8 * TOTAL;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CNT_W = $clog2(TXDONE_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TXDONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              tx_done_prev_q;
  logic              done_edge;
  logic [SR_W-1:0]   capture;

  assign done_edge = i_Tx_Done & ~tx_done_prev_q;

`ifdef TX_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      csum = csum ^ i_Packet[8*k +: 8];
    end
  end
  // Checksum rides as the least significant byte so it leaves last.
  assign capture = {i_Packet, csum};
`else
  assign capture = i_Packet;
`endif

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Send) begin
          sr_d    = capture;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_data_d  = sr_q[SR_W-1 -: 8];
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An acknowledge arriving on the limit cycle still completes the byte.
        if (done_edge) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            sr_d    = sr_q << 8;
            state_d = GAP;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      GAP: begin
        state_d = START;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b1;
      tx_done_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      tx_done_prev_q <= i_Tx_Done;
    end
  end

  assign o_Ready    = ready_q;
  assign o_Busy     = busy_q;
  assign o_Tx_Data  = tx_data_q;
  assign o_Tx_Start = tx_start_q;
  assign o_Done     = done_q;
  assign o_Timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packet_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_packet_sender: directed bench with a small Uart8 responder.     |
// | Honours TX_CHECKSUM_EN when it is defined for the build.             r1.0  |
// +----------------------------------------------------------------------------+
module tb_uart_tx_packet_sender;

`ifdef TX_CHECKSUM_EN
  localparam int NB_EXP = 3;
  localparam int NB1    = 2;
`else
  localparam int NB_EXP = 2;
  localparam int NB1    = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [15:0] packet = 16'h0000;
  logic        ready, busy, tx_start, done, tmo;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;

  logic        send1 = 1'b0;
  logic [7:0]  packet1 = 8'h00;
  logic        ready1, busy1, tx_start1, done1, tmo1;
  logic [7:0]  tx_data1;
  logic        tx_done1 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] log_b[$];
  int         log_c[$];
  int done_cnt = 0, to_cnt = 0;
  int uart_respond = 0, uart_hold = 1, resp_cnt = 0, hold_cnt = 0;

  uart_tx_packet_sender #(.NUM_BYTES(2), .TXDONE_TIMEOUT(20)) u_dut (
    .i_Clock(clk), .rst_n(rst_n), .i_Send(send), .i_Packet(packet),
    .o_Ready(ready), .o_Busy(busy), .o_Tx_Data(tx_data), .o_Tx_Start(tx_start),
    .i_Tx_Done(tx_done), .o_Done(done), .o_Timeout(tmo)
  );

  uart_tx_packet_sender #(.NUM_BYTES(1), .TXDONE_TIMEOUT(4)) u_dut1 (
    .i_Clock(clk), .rst_n(rst_n), .i_Send(send1), .i_Packet(packet1),
    .o_Ready(ready1), .o_Busy(busy1), .o_Tx_Data(tx_data1), .o_Tx_Start(tx_start1),
    .i_Tx_Done(tx_done1), .o_Done(done1), .o_Timeout(tmo1)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Uart8 stand-in: logs each start, answers 10 cycles later with a txDone of uart_hold cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_cnt = 0;
      hold_cnt = 0;
      tx_done  = 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt = hold_cnt - 1;
        if (hold_cnt == 0) tx_done = 1'b0;
      end
      if (resp_cnt > 0) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) begin
          tx_done  = 1'b1;
          hold_cnt = uart_hold;
        end
      end
      if (tx_start === 1'b1) begin
        log_b.push_back(tx_data);
        log_c.push_back(cyc);
        if (uart_respond != 0) resp_cnt = 10;
      end
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (tmo === 1'b1) to_cnt = to_cnt + 1;
  end

  task automatic send_pkt(input logic [15:0] p, output int n);
    @(negedge clk);
    packet = p;
    send   = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n    = cyc;
  endtask

  task automatic wait_end(input int budget, input int inject_at, output int end_cyc,
                          output bit saw_done, output bit saw_to, output int busy_bad);
    saw_done = 1'b0; saw_to = 1'b0; busy_bad = 0; end_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i == inject_at) begin
        send   = 1'b1;
        packet = 16'h1234;
      end else if (i == inject_at + 1) begin
        send = 1'b0;
      end
      if (done === 1'b1) begin saw_done = 1'b1; end_cyc = cyc; break; end
      if (tmo === 1'b1) begin saw_to = 1'b1; end_cyc = cyc; break; end
      if (busy !== 1'b1 || ready !== 1'b0) busy_bad++;
    end
    send = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got start=%b data=%h expected 0/00", tx_start, tx_data); end
    n_chk++; if (done !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b tmo=%b expected 0/0", done, tmo); end
    n_chk++; if (ready1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_u1: got ready=%b busy=%b expected 1/0", ready1, busy1); end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] p;
    logic [7:0]  eb [3];
    int n, ec, bb, d0;
    bit sd, st;
    p = 16'hA55A;
    eb[0] = p[15:8]; eb[1] = p[7:0]; eb[2] = p[15:8] ^ p[7:0];
    uart_respond = 1; uart_hold = 1;
    log_b.delete(); log_c.delete(); d0 = done_cnt;
    send_pkt(p, n);
    n_chk++; if (busy !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got busy=%b ready=%b expected 1/0", busy, ready); end
    wait_end(80, -1, ec, sd, st, bb);
    n_chk++; if (sd !== 1'b1 || st !== 1'b0) begin n_fail++; $display("FAIL basic_done_seen: got done=%b tmo=%b expected 1/0", sd, st); end
    n_chk++; if (ec != n + 13*NB_EXP) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", ec, n + 13*NB_EXP); end
    n_chk++; if (bb != 0) begin n_fail++; $display("FAIL basic_busy_hold: got %0d idle cycles expected 0", bb); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_end: got %b expected 1", ready); end
    n_chk++; if (log_b.size() != NB_EXP) begin n_fail++; $display("FAIL basic_nbytes: got %0d expected %0d", log_b.size(), NB_EXP); end
    for (int k = 0; k < NB_EXP && k < log_b.size(); k++) begin
      n_chk++; if (log_b[k] !== eb[k]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", k, log_b[k], eb[k]); end
      n_chk++; if (log_c[k] != n + 1 + 13*k) begin n_fail++; $display("FAIL basic_start%0d_cycle: got %0d expected %0d", k, log_c[k], n + 1 + 13*k); end
    end
    repeat (5) @(negedge clk);
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_once: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int n, ec, bb, d0;
    bit sd, st;
    uart_respond = 0;
    log_b.delete(); log_c.delete(); d0 = done_cnt;
    send_pkt(16'hA55A, n);
    wait_end(60, -1, ec, sd, st, bb);
    n_chk++; if (st !== 1'b1 || sd !== 1'b0) begin n_fail++; $display("FAIL tmo_seen: got tmo=%b done=%b expected 1/0", st, sd); end
    n_chk++; if (log_c.size() != 1 || ec != n + 21) begin n_fail++; $display("FAIL tmo_cycle: got %0d starts, tmo at %0d expected 1 start, tmo at %0d", log_c.size(), ec, n + 21); end
    n_chk++; if (log_b.size() < 1 || log_b[0] !== 8'hA5) begin n_fail++; $display("FAIL tmo_byte: got %0d bytes expected one A5", log_b.size()); end
    @(negedge clk);
    n_chk++; if (ready !== 1'b1 || busy !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_after: got ready=%b busy=%b tmo=%b expected 1/0/0", ready, busy, tmo); end
    repeat (5) @(negedge clk);
    n_chk++; if (done_cnt != d0) begin n_fail++; $display("FAIL tmo_no_done: got %0d done pulses expected 0", done_cnt - d0); end
    uart_respond = 1;
  endtask

  task automatic test_send_while_busy;
    logic [7:0] eb [3];
    int n, ec, bb;
    bit sd, st;
    eb[0] = 8'hA5; eb[1] = 8'h5A; eb[2] = 8'hFF;
    uart_respond = 1; uart_hold = 1;
    log_b.delete(); log_c.delete();
    send_pkt(16'hA55A, n);
    wait_end(80, 3, ec, sd, st, bb);
    packet = 16'h0000;
    repeat (20) @(negedge clk);
    n_chk++; if (sd !== 1'b1 || ec != n + 13*NB_EXP) begin n_fail++; $display("FAIL busy_send_done: got done=%b at %0d expected 1 at %0d", sd, ec, n + 13*NB_EXP); end
    n_chk++; if (log_b.size() != NB_EXP) begin n_fail++; $display("FAIL busy_send_count: got %0d expected %0d", log_b.size(), NB_EXP); end
    for (int k = 0; k < NB_EXP && k < log_b.size(); k++) begin
      n_chk++; if (log_b[k] !== eb[k]) begin n_fail++; $display("FAIL busy_send_byte%0d: got %h expected %h", k, log_b[k], eb[k]); end
    end
  endtask

  task automatic test_held_done;
    int n, ec, bb, d0;
    bit sd, st;
    uart_respond = 1; uart_hold = 5;
    log_b.delete(); log_c.delete(); d0 = done_cnt;
    send_pkt(16'hA55A, n);
    wait_end(80, -1, ec, sd, st, bb);
    repeat (10) @(negedge clk);
    n_chk++; if (log_b.size() != NB_EXP) begin n_fail++; $display("FAIL held_count: got %0d starts expected %0d", log_b.size(), NB_EXP); end
    n_chk++; if (log_c.size() < 2 || log_c[1] - log_c[0] != 13) begin n_fail++; $display("FAIL held_spacing: got %0d starts expected gap 13", log_c.size()); end
    n_chk++; if (sd !== 1'b1 || ec != n + 13*NB_EXP) begin n_fail++; $display("FAIL held_done: got done=%b at %0d expected 1 at %0d", sd, ec, n + 13*NB_EXP); end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL held_done_once: got %0d expected 1", done_cnt - d0); end
    uart_hold = 1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] eb [3];
    int n, ec, bb, d0, t0;
    bit sd, st;
    eb[0] = 8'h01; eb[1] = 8'h02; eb[2] = 8'h03;
    uart_respond = 1; uart_hold = 1;
    send_pkt(16'hA55A, n);
    @(negedge clk);
    n_chk++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL rst_pre_start: got %b expected 1", tx_start); end
    d0 = done_cnt; t0 = to_cnt;
    rst_n = 1'b0;
    #1;
    n_chk++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_async_tx: got start=%b data=%h expected 0/00", tx_start, tx_data); end
    n_chk++; if (busy !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_state: got busy=%b ready=%b expected 0/1", busy, ready); end
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    n_chk++; if (done_cnt != d0 || to_cnt != t0) begin n_fail++; $display("FAIL rst_no_pulse: got done=%0d tmo=%0d expected 0/0", done_cnt - d0, to_cnt - t0); end
    log_b.delete(); log_c.delete();
    send_pkt(16'h0102, n);
    wait_end(80, -1, ec, sd, st, bb);
    n_chk++; if (sd !== 1'b1 || ec != n + 13*NB_EXP) begin n_fail++; $display("FAIL rst_resend_done: got done=%b at %0d expected 1 at %0d", sd, ec, n + 13*NB_EXP); end
    n_chk++; if (log_b.size() != NB_EXP) begin n_fail++; $display("FAIL rst_resend_count: got %0d expected %0d", log_b.size(), NB_EXP); end
    for (int k = 0; k < NB_EXP && k < log_b.size(); k++) begin
      n_chk++; if (log_b[k] !== eb[k]) begin n_fail++; $display("FAIL rst_resend_byte%0d: got %h expected %h", k, log_b[k], eb[k]); end
    end
  endtask

  task automatic test_single_byte;
    int n, s_cnt, first_s, last_s, d_cyc, t_cyc;
    bit pend, bad_data;
    s_cnt = 0; first_s = -1; last_s = -1; d_cyc = -1; pend = 1'b0; bad_data = 1'b0;
    @(negedge clk); packet1 = 8'hC3; send1 = 1'b1;
    @(negedge clk); send1 = 1'b0; n = cyc;
    for (int i = 0; i < 40 && d_cyc < 0; i++) begin
      @(negedge clk);
      tx_done1 = 1'b0;
      if (tx_start1 === 1'b1) begin
        s_cnt++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
        if (tx_data1 !== 8'hC3) bad_data = 1'b1;
        pend = 1'b1;
      end else if (pend) begin
        tx_done1 = 1'b1;
        pend = 1'b0;
      end
      if (done1 === 1'b1) d_cyc = cyc;
    end
    tx_done1 = 1'b0;
    n_chk++; if (first_s != n + 1 || s_cnt != NB1) begin n_fail++; $display("FAIL one_starts: got %0d starts first at %0d expected %0d at %0d", s_cnt, first_s, NB1, n + 1); end
    n_chk++; if (bad_data) begin n_fail++; $display("FAIL one_data: got a byte other than C3 expected C3"); end
    n_chk++; if (d_cyc < 0 || d_cyc != last_s + 3) begin n_fail++; $display("FAIL one_done: got %0d expected %0d", d_cyc, last_s + 3); end
    first_s = -1; t_cyc = -1; d_cyc = -1;
    @(negedge clk); packet1 = 8'h3C; send1 = 1'b1;
    @(negedge clk); send1 = 1'b0;
    for (int i = 0; i < 20 && t_cyc < 0; i++) begin
      @(negedge clk);
      if (tx_start1 === 1'b1 && first_s < 0) first_s = cyc;
      if (tmo1 === 1'b1) t_cyc = cyc;
      if (done1 === 1'b1) d_cyc = cyc;
    end
    n_chk++; if (t_cyc < 0 || t_cyc != first_s + 4 || d_cyc >= 0) begin n_fail++; $display("FAIL one_timeout: got tmo at %0d done at %0d expected tmo at %0d no done", t_cyc, d_cyc, first_s + 4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_send_while_busy();
    test_held_done();
    test_reset_mid();
    test_single_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
